// File: rtl/seg7_tick_counter.sv
// Seven-segment digit counter for an 8-in/8-out tile slot: a prescaled tick steps the
// digit modulo MODULUS, a load edge presets it, and the glyph plus dp are registered out.
module seg7_tick_counter #(
    parameter int MAX_COUNT    = 1000,
    parameter int MODULUS      = 16,
    parameter int COMMON_ANODE = 0
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    localparam int             PW         = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;
    localparam logic [PW-1:0]  PRE_LAST   = PW'(MAX_COUNT - 1);
    localparam logic [3:0]     DIGIT_LAST = 4'(MODULUS - 1);
    localparam logic [7:0]     POLARITY   = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
    localparam logic [7:0]     OUT_RESET  = 8'h3F ^ POLARITY;

    logic clk;
    logic rst;
    assign clk = io_in[0];
    assign rst = io_in[1];

    // {data[3:0], load, run} through a two-flop synchroniser
    logic [5:0] s1_reg;
    logic [5:0] s2_reg;
    logic       prev_reg;
    logic       run_s2;
    logic       load_pulse;
    logic [3:0] data_s2;

    assign run_s2     = s2_reg[0];
    assign load_pulse = s2_reg[1] & ~prev_reg;
    assign data_s2    = s2_reg[5:2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg   <= '0;
            s2_reg   <= '0;
            prev_reg <= 1'b0;
        end else begin
            s1_reg   <= io_in[7:2];
            s2_reg   <= s1_reg;
            prev_reg <= s2_reg[1];
        end
    end

    logic [PW-1:0] prescaler_reg, prescaler_next;
    logic [3:0]    digit_reg, digit_next;
    logic          dp_reg, dp_next;
    logic          tick;

    assign tick = run_s2 && (prescaler_reg == PRE_LAST);

    // A load discards any tick landing in the same cycle.
    always_comb begin
        prescaler_next = prescaler_reg;
        digit_next     = digit_reg;
        dp_next        = dp_reg;
        if (load_pulse) begin
            prescaler_next = '0;
            digit_next     = (data_s2 > DIGIT_LAST) ? DIGIT_LAST : data_s2;
            dp_next        = 1'b0;
        end else if (tick) begin
            prescaler_next = '0;
            digit_next     = (digit_reg == DIGIT_LAST) ? 4'd0 : digit_reg + 4'd1;
            dp_next        = ~dp_reg;
        end else if (run_s2) begin
            prescaler_next = prescaler_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_reg <= '0;
            digit_reg     <= 4'd0;
            dp_reg        <= 1'b0;
        end else begin
            prescaler_reg <= prescaler_next;
            digit_reg     <= digit_next;
            dp_reg        <= dp_next;
        end
    end

    logic [6:0] seg_raw;

    always_comb begin
        case (digit_reg)
            4'h0: seg_raw = 7'h3F;
            4'h1: seg_raw = 7'h06;
            4'h2: seg_raw = 7'h5B;
            4'h3: seg_raw = 7'h4F;
            4'h4: seg_raw = 7'h66;
            4'h5: seg_raw = 7'h6D;
            4'h6: seg_raw = 7'h7D;
            4'h7: seg_raw = 7'h07;
            4'h8: seg_raw = 7'h7F;
            4'h9: seg_raw = 7'h6F;
            4'hA: seg_raw = 7'h77;
            4'hB: seg_raw = 7'h7C;
            4'hC: seg_raw = 7'h39;
            4'hD: seg_raw = 7'h5E;
            4'hE: seg_raw = 7'h79;
            4'hF: seg_raw = 7'h71;
            default: seg_raw = 7'h3F;
        endcase
    end

    logic [7:0] out_active;
    logic [7:0] out_next;
    logic [7:0] out_reg;

    assign out_active = {dp_reg, seg_raw};

    // Per-pin drive polarity for common-anode displays.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_polarity
            assign out_next[gi] = out_active[gi] ^ POLARITY[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg <= OUT_RESET;
        end else begin
            out_reg <= out_next;
        end
    end

    assign io_out = out_reg;

endmodule

// File: tb/tb_seg7_tick_counter.sv
// Drives three counter variants from one stimulus stream and scoreboards each output
// against a cycle-level reference built from input history and integer arithmetic.
module tb_seg7_tick_counter;

    localparam int MAXC = 4;
    localparam int NI   = 3;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam int MODV [NI] = '{10, 16, 10};
    localparam int CAV  [NI] = '{0, 0, 1};

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic       run  = 1'b0;
    logic       load = 1'b0;
    logic [3:0] data = 4'h0;
    logic [7:0] io_in;
    logic [7:0] out_a, out_b, out_c;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    assign io_in = {data, load, run, rst, clk};

    always #5 clk = ~clk;

    seg7_tick_counter #(.MAX_COUNT(MAXC), .MODULUS(10), .COMMON_ANODE(0)) dut_a (.io_in(io_in), .io_out(out_a));
    seg7_tick_counter #(.MAX_COUNT(MAXC), .MODULUS(16), .COMMON_ANODE(0)) dut_b (.io_in(io_in), .io_out(out_b));
    seg7_tick_counter #(.MAX_COUNT(MAXC), .MODULUS(10), .COMMON_ANODE(1)) dut_c (.io_in(io_in), .io_out(out_c));

    function automatic logic [7:0] enc(input int inst, input int d, input bit p);
        logic [7:0] v;
        v = {p, GLYPH[d]};
        if (CAV[inst] != 0) v = ~v;
        return v;
    endfunction

    function automatic logic [7:0] pick(input int inst);
        case (inst)
            0:       return out_a;
            1:       return out_b;
            default: return out_c;
        endcase
    endfunction

    // Reference model: inputs seen at an edge act two edges later; output lags state by one.
    logic [23:0] exp_q[$];
    logic [5:0]  h1 = '0, h2 = '0, h3 = '0;
    int          m_digit [NI] = '{0, 0, 0};
    int          m_pre   [NI] = '{0, 0, 0};
    bit          m_dp    [NI] = '{0, 0, 0};

    always @(posedge clk) begin
        logic [23:0] e;
        bit          lp;
        int          dval;
        cycle++;
        if (rst) begin
            h1 = '0; h2 = '0; h3 = '0;
            for (int i = 0; i < NI; i++) begin
                m_digit[i] = 0; m_pre[i] = 0; m_dp[i] = 0;
                e[i*8 +: 8] = enc(i, 0, 1'b0);
            end
        end else begin
            for (int i = 0; i < NI; i++) e[i*8 +: 8] = enc(i, m_digit[i], m_dp[i]);
            lp   = h2[1] && !h3[1];
            dval = int'(h2[5:2]);
            for (int i = 0; i < NI; i++) begin
                if (lp) begin
                    m_digit[i] = (dval > MODV[i] - 1) ? MODV[i] - 1 : dval;
                    m_pre[i]   = 0;
                    m_dp[i]    = 1'b0;
                end else if (h2[0]) begin
                    m_pre[i] = m_pre[i] + 1;
                    if (m_pre[i] == MAXC) begin
                        m_pre[i]   = 0;
                        m_digit[i] = (m_digit[i] + 1) % MODV[i];
                        m_dp[i]    = ~m_dp[i];
                    end
                end
            end
            h3 = h2; h2 = h1; h1 = {data, load, run};
        end
        exp_q.push_back(e);
    end

    // Monitor: compares every registered output against the queued expectation.
    always @(negedge clk) begin
        logic [23:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                checks++;
                if (pick(i) !== e[i*8 +: 8]) begin
                    errors++;
                    $display("FAIL scoreboard inst%0d cycle %0d: got %h expected %h", i, cycle, pick(i), e[i*8 +: 8]);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic check_reset_now(input string name);
        for (int i = 0; i < NI; i++) begin
            checks++;
            if (pick(i) !== enc(i, 0, 1'b0)) begin
                errors++;
                $display("FAIL %s inst%0d: got %h expected %h", name, i, pick(i), enc(i, 0, 1'b0));
            end
        end
    endtask

    initial begin
        wait_cyc(3);
        check_reset_now("reset_value");
        rst = 1'b0;
        wait_cyc(5);
        // Count for a while, then reset asynchronously mid-count.
        run = 1'b1;
        wait_cyc(11);
        rst = 1'b1;
        #1;
        check_reset_now("async_reset");
        wait_cyc(2);
        rst = 1'b0;
        run = 1'b0;
        wait_cyc(6);
        // Full wrap of the decade counter.
        run = 1'b1;
        wait_cyc(45);
        // Preset 7 while stopped, then resume.
        run = 1'b0; data = 4'h7; load = 1'b1;
        wait_cyc(2);
        load = 1'b0;
        wait_cyc(5);
        run = 1'b1;
        wait_cyc(10);
        // Out-of-range preset: clamps for MODULUS=10, glyph C for MODULUS=16.
        data = 4'hC; load = 1'b1;
        wait_cyc(1);
        load = 1'b0;
        wait_cyc(6);
        // Load pulses at every prescaler phase so one lands on a tick cycle.
        for (int ph = 0; ph < 2 * MAXC; ph++) begin
            data = 4'(ph + 1); load = 1'b1;
            wait_cyc(1);
            load = 1'b0;
            wait_cyc(MAXC + 1 + ph);
        end
        // Load held high across reset release, then held while running.
        data = 4'h5; load = 1'b1; rst = 1'b1;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(15);
        load = 1'b0;
        wait_cyc(3);
        // Frozen while run is low.
        run = 1'b0;
        wait_cyc(100);
        // Random traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            run  = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 5) == 0) load = ~load;
            data = 4'($urandom_range(0, 15));
            rst  = ($urandom_range(0, 119) == 0);
            wait_cyc(1);
        end
        rst = 1'b0;
        wait_cyc(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
